ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port access arbiter and clear sequencer in front of the single-port `RAM` block. It shares the RAM between two independent requesters, such as the LFSR state writer and the readout path. Each requester uses a request/grant handshake with a registered read-data return. The block also has a built-in sequencer that zero-fills the whole RAM on command, and the requesters are locked out while it runs.

## Interface
Parameters:
- `WORDS`, 1024, number of RAM cells; `ADDR_W = $clog2(WORDS)`.
- `WORD_WIDTH`, 8, data width in bits.

Ports (clock and reset are already decided):
- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `req_i[1:0]`  in  2  per-port access request, held until granted.
- `we_i[1:0]`  in  2  per-port write enable; 0 means read.
- `addr0_i`, `addr1_i`  in  ADDR_W  per-port address.
- `wdata0_i`, `wdata1_i`  in  WORD_WIDTH  per-port write data.
- `gnt_o[1:0]`  out  2  combinational one-hot grant; the access is performed in this cycle.
- `rvalid_o[1:0]`  out  2  registered pulse one cycle after a read grant.
- `rdata_o`  out  WORD_WIDTH  registered read data; valid only while some `rvalid_o` bit is high.
- `clear_i`  in  1  start zero-fill; sampled in IDLE only.
- `clear_busy_o`  out  1  high while in CLEAR.
- `clear_done_o`  out  1  one-cycle pulse when the fill completes.
- `ram_addr_o`  out  ADDR_W  RAM address.
- `ram_wr_en_o`  out  1  RAM write enable.
- `ram_wdata_o`  out  WORD_WIDTH  RAM write data.
- `ram_rdata_i`  in  WORD_WIDTH  RAM combinational read data.

## Operation
- FSM has two states, IDLE and CLEAR. The reset state is IDLE.
- IDLE:
  - At most one bit of `gnt_o` is set, and only for a requesting port.
  - The granted port's `addr`, `we` and `wdata` drive the RAM ports.
  - With no grant: `ram_wr_en_o=0`, `ram_addr_o=0`, `ram_wdata_o=0`.
- Granted read: `ram_rdata_i` is captured into `rdata_o` at the edge that ends the grant cycle, and the port's `rvalid_o` bit pulses in the next cycle.
- Granted write: the RAM commits the data at that edge. No `rvalid_o` pulse is produced.
- Contention (both `req_i` high): resolved per the Configuration section.
- `clear_i` high in IDLE:
  - Normal arbitration still happens in that same cycle.
  - The FSM enters CLEAR at the next edge, with the address counter set to 0.
- CLEAR:
  - `gnt_o=0`, `ram_wr_en_o=1`, `ram_wdata_o=0`, `ram_addr_o` = counter; the counter increments every cycle.
  - After the cycle with counter = `WORDS-1`, the FSM returns to IDLE and `clear_done_o` pulses in the first IDLE cycle.
  - `clear_i` is ignored while in CLEAR.
  - Requests stay pending because requesters must hold `req_i`.
- Reset values:
  - `gnt_o=0`, `rvalid_o=0`, `rdata_o=0`, `clear_busy_o=0`, `clear_done_o=0`.
  - Address counter 0; last-grant pointer = port 1.
- Reset mid-CLEAR: the FSM returns to IDLE, the counter returns to 0 and no `clear_done_o` pulse is produced. The partially cleared contents are not restored.

## Timing
- Grant latency: 0 cycles, since `gnt_o` is combinational from `req_i` and state.
- Read latency: 1 cycle from grant to `rvalid_o`/`rdata_o`.
- Throughput: one access per cycle. Back-to-back reads by one port yield consecutive `rvalid_o` pulses.
- Read-after-write to the same address in consecutive grants returns the new data.
- Clear duration: exactly `WORDS` cycles of `clear_busy_o`, followed by the one-cycle `clear_done_o` pulse.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined (round robin):
  - On contention, the port not granted most recently wins.
  - The last-grant pointer updates on every grant and starts at port 1, so port 0 wins the first contention after reset.
- Undefined (fixed priority):
  - Port 0 always wins contention; the pointer is absent.
  - Port 1 can starve.

## Test plan
- Write, then read, no contention:
  - Port 0 writes 0xA5 to address 3 (granted the same cycle).
  - Port 1 then reads address 3 → `gnt_o=2'b10`, and the next cycle `rvalid_o=2'b10` with `rdata_o=0xA5`.
- Sustained contention, both ports reading, for 4 cycles:
  - With `ARB_ROUND_ROBIN_EN`: grants go 01,10,01,10.
  - Without it: grants go 01,01,01,01.
- Clear during traffic:
  - Fill addresses 0..7 with 0xFF, then pulse `clear_i` with `WORDS=16`.
  - Expect `clear_busy_o` for 16 cycles, no grants, then `clear_done_o` for 1 cycle.
  - Reading addresses 0..15 afterwards returns 0.
- Simultaneous `clear_i` and a port 0 write of 0x3C to address 5: the write is granted that cycle, and after the clear address 5 reads 0.
- Reset asserted at CLEAR cycle 5:
  - The FSM is in IDLE next cycle with no `clear_done_o` pulse.
  - A subsequent `clear_i` takes a full 16 cycles.
- Back-to-back port 0 reads of addresses 1,2,3 holding 0x11,0x22,0x33 → `rvalid_o[0]` is high for 3 consecutive cycles, with `rdata_o` = 0x11, 0x22, 0x33.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port RAM access arbiter with a built-in zero-fill sequencer.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module ram_arbiter #(
  parameter  int WORDS      = 1024,
  parameter  int WORD_WIDTH = 8,
  localparam int ADDR_W     = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [ADDR_W-1:0]     addr0_i,
  input  logic [ADDR_W-1:0]     addr1_i,
  input  logic [WORD_WIDTH-1:0] wdata0_i,
  input  logic [WORD_WIDTH-1:0] wdata1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  input  logic                  clear_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic                  ram_wr_en_o,
  output logic [WORD_WIDTH-1:0] ram_wdata_o,
  input  logic [WORD_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            gnt;

`ifdef ARB_ROUND_ROBIN_EN
  // High when port 1 received the most recent grant.
  logic last_q, last_d;
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    gnt         = 2'b00;
    ram_addr_o  = '0;
    ram_wr_en_o = 1'b0;
    ram_wdata_o = '0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        unique case (req_i)
          2'b01:   gnt = 2'b01;
          2'b10:   gnt = 2'b10;
`ifdef ARB_ROUND_ROBIN_EN
          2'b11:   gnt = last_q ? 2'b01 : 2'b10;
`else
          2'b11:   gnt = 2'b01;
`endif
          default: gnt = 2'b00;
        endcase

        if (gnt[0]) begin
          ram_addr_o  = addr0_i;
          ram_wr_en_o = we_i[0];
          ram_wdata_o = wdata0_i;
        end else if (gnt[1]) begin
          ram_addr_o  = addr1_i;
          ram_wr_en_o = we_i[1];
          ram_wdata_o = wdata1_i;
        end

        // Read data is held between reads; it is only meaningful alongside rvalid.
        rvalid_d = gnt & ~we_i;
        if (rvalid_d != 2'b00) begin
          rdata_d = ram_rdata_i;
        end

`ifdef ARB_ROUND_ROBIN_EN
        if (gnt[0]) begin
          last_d = 1'b0;
        end else if (gnt[1]) begin
          last_d = 1'b1;
        end
`endif

        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end

      ST_CLEAR: begin
        ram_addr_o  = cnt_q;
        ram_wr_en_o = 1'b1;
        ram_wdata_o = '0;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  assign gnt_o        = gnt;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign clear_busy_o = (state_q == ST_CLEAR);
  assign clear_done_o = done_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of arbiter and RAM contents.
module tb_ram_arbiter;

  localparam int WORDS = 16;
  localparam int WW    = 8;
  localparam int AW    = $clog2(WORDS);

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req, we;
  logic [AW-1:0] a0, a1;
  logic [WW-1:0] d0, d1;
  logic          clr;
  logic [1:0]    gnt_o, rvalid_o;
  logic [WW-1:0] rdata_o, ram_wdata_o, ram_rdata_i;
  logic          clear_busy_o, clear_done_o, ram_wr_en_o;
  logic [AW-1:0] ram_addr_o;

  always #5 clk = ~clk;

  ram_arbiter #(.WORDS(WORDS), .WORD_WIDTH(WW)) dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we),
    .addr0_i(a0), .addr1_i(a1), .wdata0_i(d0), .wdata1_i(d1),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .clear_i(clr), .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o),
    .ram_addr_o(ram_addr_o), .ram_wr_en_o(ram_wr_en_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Single-port RAM the arbiter sits in front of.
  logic [WW-1:0] mem [WORDS];
  always @(posedge clk) if (ram_wr_en_o) mem[ram_addr_o] <= ram_wdata_o;
  assign ram_rdata_i = mem[ram_addr_o];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [WW-1:0] ref_mem [WORDS];
  bit            busy;
  int            mcnt;
  int            mlast;
  logic [1:0]    exp_rvalid;
  logic [WW-1:0] exp_rdata;
  bit            exp_done;
  logic [1:0]    last_gnt;

  task automatic model_reset();
    busy = 0; mcnt = 0; mlast = 1;
    exp_rvalid = 2'b00; exp_rdata = '0; exp_done = 0;
  endtask

  task automatic set_idle();
    req = 2'b00; we = 2'b00; clr = 1'b0;
  endtask

  // One clock cycle: inputs are already applied; check outputs, advance model, clock.
  task automatic step();
    logic [1:0] eg;
    int p;
    int addr;
    logic [WW-1:0] wd;
    bit done_n;
    logic [1:0] rv_n;
    #2;
    if (busy) eg = 2'b00;
    else if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      eg = (mlast == 1) ? 2'b01 : 2'b10;
`else
      eg = 2'b01;
`endif
    end else eg = req;
    p    = eg[1] ? 1 : 0;
    addr = (p == 1) ? int'(a1) : int'(a0);
    wd   = (p == 1) ? d1 : d0;
    last_gnt = gnt_o;

    check("gnt", gnt_o, eg);
    check("busy", clear_busy_o, busy);
    check("done", clear_done_o, exp_done);
    check("rvalid", rvalid_o, exp_rvalid);
    if (exp_rvalid != 2'b00) check("rdata", rdata_o, exp_rdata);
    if (busy) begin
      check("ram_addr", ram_addr_o, mcnt);
      check("ram_we", ram_wr_en_o, 1);
      check("ram_wdata", ram_wdata_o, 0);
    end else if (eg != 2'b00) begin
      check("ram_addr", ram_addr_o, addr);
      check("ram_we", ram_wr_en_o, we[p]);
      if (we[p]) check("ram_wdata", ram_wdata_o, wd);
    end else begin
      check("ram_addr", ram_addr_o, 0);
      check("ram_we", ram_wr_en_o, 0);
      check("ram_wdata", ram_wdata_o, 0);
    end

    done_n = 0;
    rv_n   = 2'b00;
    if (busy) begin
      ref_mem[mcnt] = '0;
      if (mcnt == WORDS - 1) begin
        busy = 0; mcnt = 0; done_n = 1;
      end else mcnt++;
    end else begin
      if (eg != 2'b00) begin
        if (we[p]) ref_mem[addr] = wd;
        else begin
          rv_n = eg;
          exp_rdata = ref_mem[addr];
        end
        mlast = p;
      end
      if (clr) begin
        busy = 1; mcnt = 0;
      end
    end
    exp_done   = done_n;
    exp_rvalid = rv_n;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    #2;
    if (busy) ref_mem[mcnt] = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check("rst_rdata", rdata_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_busy", clear_busy_o, 0);
    check("rst_done", clear_done_o, 0);
  endtask

  task automatic do_access(input int port, input bit w, input int addr, input int data);
    set_idle();
    req[port] = 1'b1;
    we[port]  = w;
    if (port == 0) begin a0 = AW'(addr); d0 = WW'(data); end
    else begin a1 = AW'(addr); d1 = WW'(data); end
    step();
    set_idle();
  endtask

  task automatic run_clear(output int n);
    n = 0;
    while (clear_busy_o && n < 40) begin
      step();
      n++;
    end
  endtask

  int n;
  logic [1:0]    rv_seen [3];
  logic [WW-1:0] rd_seen [3];

  initial begin
    set_idle();
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    do_reset();
    step();

    // Zero-fill so the reference memory is known.
    clr = 1'b1; step(); clr = 1'b0;
    run_clear(n);
    check("init_clear_len", n, WORDS);
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
    step();

    // Write then read, no contention.
    do_access(0, 1, 3, 8'hA5);
    check("wr_gnt", last_gnt, 2'b01);
    do_access(1, 0, 3, 0);
    check("rd_gnt", last_gnt, 2'b10);
    check("rd_rvalid", rvalid_o, 2'b10);
    check("rd_rdata", rdata_o, 8'hA5);
    step();

    // Sustained contention after reset.
    do_reset();
    req = 2'b11; we = 2'b00; a0 = 4'd3; a1 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef ARB_ROUND_ROBIN_EN
      check("rr_gnt", last_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      check("fixed_gnt", last_gnt, 2'b01);
`endif
    end
    set_idle(); step();

    // Clear during traffic.
    for (int i = 0; i < 8; i++) do_access(0, 1, i, 8'hFF);
    req = 2'b10; a1 = 4'd0; clr = 1'b1; step();
    clr = 1'b0; req = 2'b11;
    run_clear(n);
    check("clear_len", n, WORDS);
    set_idle();
    check("clear_done_pulse", clear_done_o, 1);
    for (int i = 0; i < WORDS; i++) do_access(0, 0, i, 0);
    step();
    check("clear_done_once", clear_done_o, 0);

    // Clear coinciding with a port 0 write.
    req = 2'b01; we = 2'b01; a0 = 4'd5; d0 = 8'h3C; clr = 1'b1;
    step();
    check("clr_wr_gnt", last_gnt, 2'b01);
    set_idle();
    run_clear(n);
    do_access(0, 0, 5, 0);
    check("clr_wr_rdata", rdata_o, 0);
    step();

    // Reset at clear cycle 5.
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    step();
    clr = 1'b1; step(); clr = 1'b0;
    run_clear(n);
    check("clear_after_reset_len", n, WORDS);
    step();

    // Back-to-back reads.
    do_access(0, 1, 1, 8'h11);
    do_access(0, 1, 2, 8'h22);
    do_access(0, 1, 3, 8'h33);
    for (int i = 0; i < 3; i++) begin
      do_access(0, 0, i + 1, 0);
      rv_seen[i] = rvalid_o;
      rd_seen[i] = rdata_o;
    end
    check("b2b_rv0", rv_seen[0], 2'b01); check("b2b_rd0", rd_seen[0], 8'h11);
    check("b2b_rv1", rv_seen[1], 2'b01); check("b2b_rd1", rd_seen[1], 8'h22);
    check("b2b_rv2", rv_seen[2], 2'b01); check("b2b_rd2", rd_seen[2], 8'h33);
    step();

    // Random traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      req = 2'($urandom);
      we  = 2'($urandom);
      a0  = AW'($urandom);
      a1  = AW'($urandom);
      d0  = WW'($urandom);
      d1  = WW'($urandom);
      clr = ($urandom_range(0, 59) == 0);
      step();
    end
    set_idle();
    for (int i = 0; i < WORDS + 2; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
